// File: rtl/l2_tlb.sv
// l2_tlb: 64-entry joint MIPS TLB serving TLBP/TLBR/TLBWI/TLBWR and L1 refills through one chunked scan engine.
// Optional macro L2TLB_LASTHIT_EN: repeat refills that hit the last refill entry are answered without a scan.
module l2_tlb #(
  parameter int SCAN_W = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tlbp_en,
  input  logic        tlbr_en,
  input  logic        tlbwi_en,
  input  logic        tlbwr_en,
  input  logic [5:0]  cp0_index,
  input  logic [5:0]  cp0_random,
  input  logic [31:0] cp0_entryhi,
  input  logic [31:0] cp0_entrylo0,
  input  logic [31:0] cp0_entrylo1,
  input  logic [15:0] cp0_pagemask,
  output logic [78:0] tlb_new,
  output logic [15:0] pagemask_new,
  output logic        qry_done,
  output logic        qry_isexist,
  output logic [5:0]  index_new,
  input  logic        ref_req,
  input  logic [31:0] ref_vaddr,
  input  logic [7:0]  ref_asid,
  output logic        ref_ready,
  output logic        ref_resp,
  output logic        ref_hit,
  output logic [78:0] ref_entry,
  output logic [15:0] ref_pagemask
);
  localparam int NCHUNK = 64 / SCAN_W;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef enum logic {SRC_PROBE, SRC_REF} src_t;

  // Entry layout: {VPN2[78:60], ASID[59:52], Lo1[51:26], Lo0[25:0]}
  logic [78:0]   ent [64];
  logic [15:0]   msk [64];
  state_t        state;
  src_t          src;
  logic [18:0]   key_vpn2;
  logic [7:0]    key_asid;
  logic [CW-1:0] chunk;
  logic          acc_hit;
  logic [5:0]    acc_idx;
  logic          restart;
  logic          probe_lock;

  logic          wr_en;
  logic [5:0]    wr_idx;
  logic [78:0]   wr_data;
  logic          probe_go;
  logic          chunk_hit;
  logic [5:0]    chunk_idx;
  logic [5:0]    cand;
  logic          fin_hit;
  logic [5:0]    fin_idx;
  logic          scan_last;
  logic          lh_fast;
  logic [5:0]    lh_idx;
  logic          unused_bits;

  function automatic logic ent_match(input logic [78:0] e, input logic [15:0] m,
                                     input logic [18:0] vpn2, input logic [7:0] asid);
    logic [18:0] mk;
    logic        g;
    mk = {3'b000, m};
    g  = e[26] & e[0];
    return ((((e[78:60] ^ vpn2) & ~mk) == 19'd0) && (g || (e[59:52] == asid)));
  endfunction

  assign wr_en   = tlbwi_en | tlbwr_en;
  assign wr_idx  = tlbwi_en ? cp0_index : cp0_random;
  assign wr_data = {cp0_entryhi[31:13], cp0_entryhi[7:0], cp0_entrylo1[25:0], cp0_entrylo0[25:0]};

  assign tlb_new      = ent[cp0_index];
  assign pagemask_new = msk[cp0_index];

  assign probe_go  = tlbp_en & ~probe_lock;
  assign ref_ready = resetn && (state == IDLE) && !probe_go && ref_req;
  assign unused_bits = ^{tlbr_en, cp0_entryhi[12:8], cp0_entrylo0[31:26], cp0_entrylo1[31:26],
                         ref_vaddr[12:0]};

  // Lowest matching index within the current chunk
  always_comb begin
    chunk_hit = 1'b0;
    chunk_idx = '0;
    cand      = '0;
    for (int j = SCAN_W - 1; j >= 0; j--) begin
      cand = 6'(int'(chunk) * SCAN_W + j);
      if (ent_match(ent[cand], msk[cand], key_vpn2, key_asid)) begin
        chunk_hit = 1'b1;
        chunk_idx = cand;
      end
    end
  end

  assign fin_hit   = acc_hit | chunk_hit;
  assign fin_idx   = acc_hit ? acc_idx : chunk_idx;
  assign scan_last = (state == SCAN) && !wr_en && !restart && (chunk == LAST);

`ifdef L2TLB_LASTHIT_EN
  logic lh_valid;

  assign lh_fast = lh_valid && !wr_en &&
                   ent_match(ent[lh_idx], msk[lh_idx], ref_vaddr[31:13], ref_asid);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lh_valid <= 1'b0;
      lh_idx   <= '0;
    end else if (wr_en) begin
      lh_valid <= 1'b0;
    end else if (scan_last && (src == SRC_REF) && fin_hit) begin
      lh_valid <= 1'b1;
      lh_idx   <= fin_idx;
    end
  end
`else
  assign lh_fast = 1'b0;
  assign lh_idx  = '0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 64; i++) begin
        ent[i] <= '0;
        msk[i] <= '0;
      end
      state        <= IDLE;
      src          <= SRC_PROBE;
      key_vpn2     <= '0;
      key_asid     <= '0;
      chunk        <= '0;
      acc_hit      <= 1'b0;
      acc_idx      <= '0;
      restart      <= 1'b0;
      probe_lock   <= 1'b0;
      qry_done     <= 1'b0;
      qry_isexist  <= 1'b0;
      index_new    <= '0;
      ref_resp     <= 1'b0;
      ref_hit      <= 1'b0;
      ref_entry    <= '0;
      ref_pagemask <= '0;
    end else begin
      if (wr_en) begin
        ent[wr_idx] <= wr_data;
        msk[wr_idx] <= cp0_pagemask;
      end
      qry_done <= 1'b0;
      ref_resp <= 1'b0;
      restart  <= 1'b0;
      if (!tlbp_en) probe_lock <= 1'b0;

      case (state)
        IDLE: begin
          chunk   <= '0;
          acc_hit <= 1'b0;
          acc_idx <= '0;
          if (probe_go) begin
            key_vpn2 <= cp0_entryhi[31:13];
            key_asid <= cp0_entryhi[7:0];
            src      <= SRC_PROBE;
            state    <= SCAN;
          end else if (ref_req && lh_fast) begin
            src          <= SRC_REF;
            ref_resp     <= 1'b1;
            ref_hit      <= 1'b1;
            ref_entry    <= ent[lh_idx];
            ref_pagemask <= msk[lh_idx];
            state        <= DONE;
          end else if (ref_req) begin
            key_vpn2 <= ref_vaddr[31:13];
            key_asid <= ref_asid;
            src      <= SRC_REF;
            state    <= SCAN;
          end
        end
        SCAN: begin
          // A write invalidates partial results; one settle cycle follows before chunk 0 is rescanned
          if (wr_en || restart) begin
            chunk   <= '0;
            acc_hit <= 1'b0;
            acc_idx <= '0;
            restart <= wr_en;
          end else if (chunk == LAST) begin
            state <= DONE;
            if (src == SRC_PROBE) begin
              qry_done    <= 1'b1;
              qry_isexist <= fin_hit;
              index_new   <= fin_hit ? fin_idx : 6'd0;
              probe_lock  <= 1'b1;
            end else begin
              ref_resp     <= 1'b1;
              ref_hit      <= fin_hit;
              ref_entry    <= fin_hit ? ent[fin_idx] : 79'd0;
              ref_pagemask <= fin_hit ? msk[fin_idx] : 16'd0;
            end
          end else begin
            chunk <= chunk + CW'(1);
            if (chunk_hit && !acc_hit) begin
              acc_hit <= 1'b1;
              acc_idx <= chunk_idx;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_tlb.sv
// tb_l2_tlb: table-driven probe/refill vectors plus directed sequences for TLBR, mid-scan write, arbitration and reset.
module tb_l2_tlb;
  logic        clk = 1'b0;
  logic        resetn;
  logic        tlbp_en, tlbr_en, tlbwi_en, tlbwr_en;
  logic [5:0]  cp0_index, cp0_random;
  logic [31:0] cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
  logic [15:0] cp0_pagemask;
  logic [78:0] tlb_new;
  logic [15:0] pagemask_new;
  logic        qry_done, qry_isexist;
  logic [5:0]  index_new;
  logic        ref_req;
  logic [31:0] ref_vaddr;
  logic [7:0]  ref_asid;
  logic        ref_ready, ref_resp, ref_hit;
  logic [78:0] ref_entry;
  logic [15:0] ref_pagemask;

  l2_tlb dut (
    .clk(clk), .resetn(resetn), .tlbp_en(tlbp_en), .tlbr_en(tlbr_en),
    .tlbwi_en(tlbwi_en), .tlbwr_en(tlbwr_en), .cp0_index(cp0_index), .cp0_random(cp0_random),
    .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
    .cp0_pagemask(cp0_pagemask), .tlb_new(tlb_new), .pagemask_new(pagemask_new),
    .qry_done(qry_done), .qry_isexist(qry_isexist), .index_new(index_new),
    .ref_req(ref_req), .ref_vaddr(ref_vaddr), .ref_asid(ref_asid), .ref_ready(ref_ready),
    .ref_resp(ref_resp), .ref_hit(ref_hit), .ref_entry(ref_entry), .ref_pagemask(ref_pagemask)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_wr;
    logic [5:0]  widx;
    logic [31:0] hi;
    logic [31:0] lo0;
    logic [31:0] lo1;
    logic [15:0] pm;
    bit          is_probe;
    logic [31:0] key;
    logic [7:0]  asid;
    bit          exp_hit;
    logic [5:0]  exp_idx;
  } vec_t;

  vec_t        vecs[10];
  vec_t        g;
  logic [78:0] sh_ent [64];
  logic [15:0] sh_pm  [64];
  int          tests = 0;
  int          fails = 0;

  function automatic logic [78:0] pack(input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
    return {hi[31:13], hi[7:0], lo1[25:0], lo0[25:0]};
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_shadow();
    for (int i = 0; i < 64; i++) begin
      sh_ent[i] = '0;
      sh_pm[i]  = '0;
    end
  endtask

  task automatic tlbwi(input logic [5:0] idx, input logic [31:0] hi, input logic [31:0] lo0,
                       input logic [31:0] lo1, input logic [15:0] pm);
    cp0_index = idx; cp0_entryhi = hi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1; cp0_pagemask = pm;
    tlbwi_en = 1'b1;
    sh_ent[idx] = pack(hi, lo0, lo1);
    sh_pm[idx]  = pm;
    step();
    tlbwi_en = 1'b0;
  endtask

  task automatic run_query(input vec_t v, input string tag);
    int lat;
    int extra;
    logic rdy;
    lat = 0; extra = 0; rdy = 1'b0;
    if (v.is_probe) begin
      cp0_entryhi = v.key;
      tlbp_en = 1'b1;
      for (int n = 1; n <= 40 && lat == 0; n++) begin
        step();
        if (qry_done) lat = n;
      end
      chk({tag, " latency"}, 96'(lat), 96'(9));
      chk({tag, " isexist"}, 96'(qry_isexist), 96'(v.exp_hit));
      chk({tag, " index"}, 96'(index_new), 96'(v.exp_idx));
      for (int n = 0; n < 12; n++) begin
        step();
        if (qry_done) extra++;
      end
      chk({tag, " repulse"}, 96'(extra), 96'(0));
      tlbp_en = 1'b0;
      step();
    end else begin
      ref_vaddr = v.key;
      ref_asid  = v.asid;
      ref_req   = 1'b1;
      #1;
      rdy = ref_ready;
      for (int n = 1; n <= 40 && lat == 0; n++) begin
        step();
        ref_req = 1'b0;
        if (ref_resp) lat = n;
      end
      chk({tag, " ready"}, 96'(rdy), 96'(1));
      chk({tag, " latency"}, 96'(lat), 96'(9));
      chk({tag, " hit"}, 96'(ref_hit), 96'(v.exp_hit));
      chk({tag, " entry"}, 96'(ref_entry), 96'(v.exp_hit ? sh_ent[v.exp_idx] : 79'd0));
      chk({tag, " pagemask"}, 96'(ref_pagemask), 96'(v.exp_hit ? sh_pm[v.exp_idx] : 16'd0));
      step();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, qd, rr, rp, overlap, pulses;
    //           wr    widx    hi            lo0           lo1           pm        probe  key           asid   hit   idx
    vecs[0] = '{1'b0, 6'd0,  32'h00000000, 32'h00000000, 32'h00000000, 16'h0000, 1'b1, 32'h00000000, 8'h00, 1'b1, 6'd0};
    vecs[1] = '{1'b1, 6'd37, 32'h2468A005, 32'h00001234, 32'h00005678, 16'h0000, 1'b1, 32'h2468A005, 8'h00, 1'b1, 6'd37};
    vecs[2] = '{1'b0, 6'd0,  32'h00000000, 32'h00000000, 32'h00000000, 16'h0000, 1'b1, 32'h2468A006, 8'h00, 1'b0, 6'd0};
    vecs[3] = '{1'b1, 6'd10, 32'h00200001, 32'h00000100, 32'h00000200, 16'h0003, 1'b0, 32'h00200000, 8'h01, 1'b1, 6'd10};
    vecs[4] = '{1'b1, 6'd20, 32'h00206001, 32'h00000300, 32'h00000400, 16'h0000, 1'b0, 32'h00206000, 8'h01, 1'b1, 6'd10};
    vecs[5] = '{1'b0, 6'd0,  32'h00000000, 32'h00000000, 32'h00000000, 16'h0000, 1'b0, 32'h00206000, 8'h02, 1'b0, 6'd0};
    vecs[6] = '{1'b0, 6'd0,  32'h00000000, 32'h00000000, 32'h00000000, 16'h0000, 1'b1, 32'h0020E001, 8'h00, 1'b0, 6'd0};
    vecs[7] = '{1'b0, 6'd0,  32'h00000000, 32'h00000000, 32'h00000000, 16'h0000, 1'b0, 32'h2468BFFF, 8'h05, 1'b1, 6'd37};
    vecs[8] = '{1'b1, 6'd62, 32'h0000E055, 32'h00000001, 32'h00000000, 16'h0000, 1'b0, 32'h0000E123, 8'h55, 1'b1, 6'd62};
    vecs[9] = '{1'b0, 6'd0,  32'h00000000, 32'h00000000, 32'h00000000, 16'h0000, 1'b0, 32'h0000E123, 8'h56, 1'b0, 6'd0};

    resetn = 1'b0; tlbp_en = 1'b0; tlbr_en = 1'b0; tlbwi_en = 1'b0; tlbwr_en = 1'b0;
    cp0_index = 6'd37; cp0_random = 6'd0; cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0;
    cp0_pagemask = '0; ref_req = 1'b0; ref_vaddr = '0; ref_asid = '0;
    clear_shadow();
    repeat (3) step();
    resetn = 1'b1;
    step();

    chk("rst qry_done", 96'(qry_done), 96'(0));
    chk("rst qry_isexist", 96'(qry_isexist), 96'(0));
    chk("rst index_new", 96'(index_new), 96'(0));
    chk("rst ref_resp", 96'(ref_resp), 96'(0));
    chk("rst ref_hit", 96'(ref_hit), 96'(0));
    chk("rst ref_entry", 96'(ref_entry), 96'(0));
    chk("rst ref_ready", 96'(ref_ready), 96'(0));
    chk("rst tlb_new", 96'(tlb_new), 96'(0));

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_wr) tlbwi(vecs[i].widx, vecs[i].hi, vecs[i].lo0, vecs[i].lo1, vecs[i].pm);
      run_query(vecs[i], $sformatf("v%0d", i));
    end

    // TLBR read, no write forwarding, tlbwi priority over tlbwr
    cp0_index = 6'd37; tlbr_en = 1'b1;
    #1;
    chk("tlbr entry", 96'(tlb_new), 96'(sh_ent[37]));
    chk("tlbr pagemask", 96'(pagemask_new), 96'(sh_pm[37]));
    cp0_entryhi = 32'h2468A005; cp0_entrylo0 = 32'hFC001235; cp0_entrylo1 = 32'h03005679;
    cp0_pagemask = 16'h0000; cp0_random = 6'd5; tlbwi_en = 1'b1; tlbwr_en = 1'b1;
    #1;
    chk("tlbr no-forward", 96'(tlb_new), 96'(sh_ent[37]));
    sh_ent[37] = pack(32'h2468A005, 32'hFC001235, 32'h03005679);
    step();
    tlbwi_en = 1'b0; tlbwr_en = 1'b0; tlbr_en = 1'b0;
    #1;
    chk("tlbr after write", 96'(tlb_new), 96'(sh_ent[37]));
    cp0_index = 6'd5;
    #1;
    chk("tlbwr suppressed", 96'(tlb_new), 96'(sh_ent[5]));
    g = '{1'b0, 6'd0, 32'h0, 32'h0, 32'h0, 16'h0, 1'b1, 32'h2468A006, 8'h00, 1'b1, 6'd37};
    run_query(g, "global");

    // Write during SCAN restarts the probe
    cp0_entryhi = 32'h7579A022; cp0_entrylo0 = '0; cp0_entrylo1 = '0; cp0_pagemask = '0;
    cp0_random = 6'd63; tlbp_en = 1'b1; lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      step();
      tlbwr_en = (n == 4);
      if (qry_done) lat = n;
    end
    tlbwr_en = 1'b0;
    sh_ent[63] = pack(32'h7579A022, 32'h0, 32'h0);
    chk("midscan latency", 96'(lat), 96'(14));
    chk("midscan isexist", 96'(qry_isexist), 96'(1));
    chk("midscan index", 96'(index_new), 96'(63));
    tlbp_en = 1'b0;
    step(); step();

    // Probe and refill together: probe first, refill accepted right after
    cp0_entryhi = 32'h2468A005; tlbp_en = 1'b1;
    ref_vaddr = 32'h00206000; ref_asid = 8'h01; ref_req = 1'b1;
    #1;
    chk("arb ready at T", 96'(ref_ready), 96'(0));
    qd = 0; rr = 0; rp = 0; overlap = 0;
    for (int n = 1; n <= 60 && rp == 0; n++) begin
      step();
      if (qd != 0) tlbp_en = 1'b0;
      if (rr != 0) ref_req = 1'b0;
      #1;
      if (qry_done && qd == 0) qd = n;
      if (ref_ready && rr == 0) rr = n;
      if (ref_resp) rp = n;
      if (int'(qry_done) + int'(ref_ready) + int'(ref_resp) > 1) overlap++;
    end
    tlbp_en = 1'b0; ref_req = 1'b0;
    chk("arb qry_done", 96'(qd), 96'(9));
    chk("arb ref_ready", 96'(rr), 96'(10));
    chk("arb ref_resp", 96'(rp), 96'(19));
    chk("arb overlap", 96'(overlap), 96'(0));
    chk("arb probe idx", 96'(index_new), 96'(37));
    chk("arb ref_hit", 96'(ref_hit), 96'(1));
    chk("arb ref_entry", 96'(ref_entry), 96'(sh_ent[10]));
    step();

    // Reset in the middle of a scan
    cp0_entryhi = 32'h2468A005; tlbp_en = 1'b1; pulses = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == 3) begin
        resetn = 1'b0;
        tlbp_en = 1'b0;
      end else begin
        resetn = 1'b1;
      end
      if (qry_done || ref_resp) pulses++;
    end
    clear_shadow();
    chk("reset no pulse", 96'(pulses), 96'(0));
    cp0_index = 6'd37;
    #1;
    chk("reset cleared entry", 96'(tlb_new), 96'(sh_ent[37]));
    g = '{1'b0, 6'd0, 32'h0, 32'h0, 32'h0, 16'h0, 1'b0, 32'h00000000, 8'h00, 1'b1, 6'd0};
    run_query(g, "post-reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/l2_tlb.md
Name: l2_tlb

Overview:
- 64-entry joint TLB (L2) that holds the architectural MIPS TLB state.
- Serves TLBP probes and TLBR reads for the CP0 register group, and TLBWI/TLBWR writes sourced from CP0.
- Serves refill lookups for the L1 I/D TLBs.
- One shared multi-cycle scan engine compares SCAN_W entries per cycle.

Parameters:
- SCAN_W, 8, entries compared per scan cycle; must divide 64.
- NCHUNK, 64/SCAN_W, derived; scan cycles per lookup.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- tlbp_en  in  1  probe request; level, held by commit until qry_done
- tlbr_en  in  1  TLBR, single-cycle
- tlbwi_en  in  1  write at cp0_index, single-cycle
- tlbwr_en  in  1  write at cp0_random, single-cycle
- cp0_index  in  6  CP0 Index.index
- cp0_random  in  6  CP0 Random
- cp0_entryhi  in  32  {VPN2[31:13],5'b0,ASID[7:0]}
- cp0_entrylo0  in  32  EntryLo0; bits[25:0] stored
- cp0_entrylo1  in  32  EntryLo1; bits[25:0] stored
- cp0_pagemask  in  16  PageMask[28:13] raw
- tlb_new  out  79  {VPN2,ASID,Lo1[25:0],Lo0[25:0]} of entry[cp0_index]; combinational
- pagemask_new  out  16  PageMask of entry[cp0_index]; combinational
- qry_done  out  1  probe result pulse
- qry_isexist  out  1  probe hit
- index_new  out  6  probe hit index (0 on miss)
- ref_req  in  1  L1 refill request
- ref_vaddr  in  32  refill vaddr
- ref_asid  in  8  refill ASID
- ref_ready  out  1  refill request accepted this cycle
- ref_resp  out  1  refill result pulse
- ref_hit  out  1  refill hit
- ref_entry  out  79  matched entry, same layout as tlb_new
- ref_pagemask  out  16  matched PageMask

Behaviour:
- Storage: 64 × (79-bit entry + 16-bit mask) in flops. All entries, outputs, state = 0 on reset.
- Zeroed entries do match VPN2 0 / ASID 0. This is accepted; software initialises the TLB.
- Write: tlbwi_en / tlbwr_en write {entryhi VPN2, ASID, lo1[25:0], lo0[25:0]} and pagemask at the next edge.
  - Both asserted: tlbwi wins.
  - Writes are accepted in every state, never stall.
- Read: tlb_new / pagemask_new index entry[cp0_index] combinationally, so CP0 latches them in the tlbr_en cycle.
  - A same-cycle write to that index is not forwarded; the old value is returned.
- Match, entry i against key (vpn2, asid):
  - G = Lo0[0] & Lo1[0].
  - m = {3'b0, mask[15:0]} masks low VPN2 bits.
  - Hit if (VPN2_i & ~m) == (vpn2 & ~m) and (G | ASID_i == asid).
  - Multiple hits: lowest index wins.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - tlbp_en && !probe_lock → latch key from cp0_entryhi; src = PROBE; go to SCAN.
  - Else ref_req → ref_ready = 1 (combinational, this cycle only); latch key from ref_vaddr[31:13], ref_asid; src = REF; go to SCAN.
  - Probe has priority over refill.
- SCAN:
  - chunk counter c = 0..NCHUNK-1; compares entries c*SCAN_W..c*SCAN_W+SCAN_W-1.
  - Accumulates first hit in a registered hit/index.
  - After c = NCHUNK-1, go to DONE.
- DONE: one cycle; returns to IDLE.
  - src = PROBE: qry_done = 1, qry_isexist = hit, index_new = hit ? idx : 0; set probe_lock.
  - src = REF: ref_resp = 1, ref_hit = hit, ref_entry / ref_pagemask = entry[idx] (0 on miss).
- Latency: request seen at cycle T; SCAN at T+1..T+NCHUNK; DONE pulse at T+NCHUNK+1. Default: T+9.
- probe_lock:
  - Cleared when tlbp_en = 0.
  - Prevents a held tlbp_en from re-probing in the cycle after qry_done.
- Write during SCAN: c resets to 0 and accumulated hit clears next cycle; the scan restarts. Latency extends accordingly.
- Write in the IDLE accept cycle: no restart needed; the scan starts after the write lands.
- Write during DONE: the result is delivered unchanged.
- qry_done, ref_resp, ref_ready are never high simultaneously. Response outputs other than the pulses hold their last values.
- Reset mid-scan: return to IDLE, no pulse emitted, probe_lock cleared.

Optional Feature:
- Macro: L2TLB_LASTHIT_EN.
- Defined:
  - A register holds the last refill hit index plus a valid bit.
  - In IDLE, ref_req whose key matches that entry responds ref_resp / ref_hit = 1 at T+1, skipping SCAN.
  - Any write clears the valid bit. Probes never use it.
- Undefined: all refills take the full scan latency.

Test Plan:
- Probe hit: tlbwi index 37 {VPN2=0x12345, ASID=0x05, G=0}; probe EntryHi 0x2468A005 held → qry_done at T+9, isexist=1, index_new=37; no second pulse while tlbp_en stays high.
- Probe miss and ASID: same entry, probe ASID 0x06 → isexist=0, index_new=0. Set G bits, rewrite, repeat → hit, index 37.
- PageMask / multi-hit: entry 10 mask 0x0003 VPN2 0x00100, entry 20 VPN2 0x00103 mask 0 → refill vaddr 0x00206000 → ref_hit, entry 10 returned.
- TLBR: cp0_index=37, tlbr_en → tlb_new equals the written 79-bit value in the same cycle; pagemask_new matches.
- Write mid-scan: start probe for VPN2 X (miss), tlbwr at cycle T+4 writes X at random=63 → scan restarts, qry_done at T+14, isexist=1, index 63.
- Arbitration/reset: tlbp_en and ref_req asserted together → probe served first, ref_ready at T+10. Reset at T+3 → no pulses; FSM back in IDLE.
